// File: rtl/maze_game_pkg.sv
// Shared types and parameter checks for the maze session controller and its level timer.
package maze_game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN_REQ,
    S_GEN_WAIT,
    S_PLAY,
    S_LEVEL_DONE,
    S_GAME_OVER
  } session_state_t;

  localparam int LIVES_WIDTH = 4;

  function automatic bit time_limit_ok(input int time_limit, input int timer_width);
    return (time_limit >= 1) && (time_limit <= (1 << timer_width) - 1);
  endfunction

  function automatic bit lives_ok(input int lives);
    return (lives >= 1) && (lives <= (1 << LIVES_WIDTH) - 1);
  endfunction

endpackage

// File: rtl/maze_level_timer.sv
// Loadable per-level countdown; expire flags the tick that takes the count from 1 to 0.
module maze_level_timer #(
  parameter int TIMER_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic [TIMER_WIDTH-1:0] load_value,
  input  logic                   tick,
  output logic [TIMER_WIDTH-1:0] count,
  output logic                   expire
);

  // Combinational so the controller can act on expiry in the same cycle as the last tick.
  assign expire = tick && !load && (count == TIMER_WIDTH'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - TIMER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/maze_session_controller.sv
// Multi-level maze session sequencer: generator handshake, level timer, lives and score.
// Optional high-score register enabled by defining MAZE_SESSION_HIGH_SCORE_EN.
module maze_session_controller
  import maze_game_pkg::*;
#(
  parameter int COUNT_WIDTH = 8,
  parameter int TIMER_WIDTH = 8,
  parameter int TIME_LIMIT  = 60,
  parameter int LIVES       = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   tick,
  input  logic                   player_at_end,
  input  logic                   gen_end,
  output logic                   gen_start,
  output logic                   reset_player,
  output logic [TIMER_WIDTH-1:0] time_left,
  output logic [LIVES_WIDTH-1:0] lives,
  output logic [COUNT_WIDTH-1:0] mazes_complete,
`ifdef MAZE_SESSION_HIGH_SCORE_EN
  output logic [COUNT_WIDTH-1:0] high_score,
`endif
  output logic                   playing,
  output logic                   game_over,
  output session_state_t         session_state
);

  if (!time_limit_ok(TIME_LIMIT, TIMER_WIDTH)) begin : g_bad_time_limit
    $error("TIME_LIMIT out of range for TIMER_WIDTH");
  end
  if (!lives_ok(LIVES)) begin : g_bad_lives
    $error("LIVES out of range");
  end

  logic busy_seen;
  logic prev_at_end;
  logic exit_edge;
  logic timer_tick;
  logic timer_load;
  logic expire;

  assign exit_edge  = player_at_end && !prev_at_end;
  // A completion outranks the tick in the same cycle, so the timer must not move then.
  assign timer_tick = (session_state == S_PLAY) && tick && !exit_edge;
  assign timer_load = (session_state == S_GEN_WAIT) && busy_seen && gen_end;

  maze_level_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (TIMER_WIDTH'(TIME_LIMIT)),
    .tick       (timer_tick),
    .count      (time_left),
    .expire     (expire)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      session_state  <= S_IDLE;
      gen_start      <= 1'b0;
      reset_player   <= 1'b1;
      lives          <= '0;
      mazes_complete <= '0;
      playing        <= 1'b0;
      game_over      <= 1'b0;
      busy_seen      <= 1'b0;
      prev_at_end    <= 1'b0;
`ifdef MAZE_SESSION_HIGH_SCORE_EN
      high_score     <= '0;
`endif
    end else begin
      prev_at_end <= player_at_end;
      gen_start   <= 1'b0;
      case (session_state)
        S_IDLE, S_GAME_OVER: begin
          if (start) begin
            mazes_complete <= '0;
            lives          <= LIVES_WIDTH'(LIVES);
            game_over      <= 1'b0;
            gen_start      <= 1'b1;
            session_state  <= S_GEN_REQ;
          end
        end
        S_GEN_REQ: begin
          busy_seen     <= 1'b0;
          session_state <= S_GEN_WAIT;
        end
        S_GEN_WAIT: begin
          // Only a maze produced after a visible busy phase releases the wait.
          if (!gen_end) begin
            busy_seen <= 1'b1;
          end else if (busy_seen) begin
            playing       <= 1'b1;
            reset_player  <= 1'b0;
            session_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (exit_edge) begin
            if (mazes_complete != '1) mazes_complete <= mazes_complete + COUNT_WIDTH'(1);
            playing       <= 1'b0;
            reset_player  <= 1'b1;
            session_state <= S_LEVEL_DONE;
          end else if (expire) begin
            lives        <= lives - LIVES_WIDTH'(1);
            playing      <= 1'b0;
            reset_player <= 1'b1;
            if (lives == LIVES_WIDTH'(1)) begin
              game_over     <= 1'b1;
              session_state <= S_GAME_OVER;
`ifdef MAZE_SESSION_HIGH_SCORE_EN
              if (mazes_complete > high_score) high_score <= mazes_complete;
`endif
            end else begin
              gen_start     <= 1'b1;
              session_state <= S_GEN_REQ;
            end
          end
        end
        S_LEVEL_DONE: begin
          gen_start     <= 1'b1;
          session_state <= S_GEN_REQ;
        end
        default: session_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_session_controller.sv
// Directed bench for maze_session_controller; a default instance plus a small one (COUNT_WIDTH=2, TIME_LIMIT=2).
module tb_maze_session_controller;
  import maze_game_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic player_at_end = 1'b0;
  logic gen_end = 1'b1;

  logic       a_gen_start, a_reset_player, a_playing, a_game_over;
  logic [7:0] a_time_left, a_mazes;
  logic [3:0] a_lives;
  session_state_t a_state;
`ifdef MAZE_SESSION_HIGH_SCORE_EN
  logic [7:0] a_high_score;
  logic [1:0] b_high_score;
`endif
  logic       b_gen_start, b_reset_player, b_playing, b_game_over;
  logic [7:0] b_time_left;
  logic [1:0] b_mazes;
  logic [3:0] b_lives;
  session_state_t b_state;

  int compared = 0;
  int mismatched = 0;
  int a_pulses = 0;

  always #5 clock = ~clock;

  always @(negedge clock) if (a_gen_start) a_pulses++;

  maze_session_controller dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick),
    .player_at_end(player_at_end), .gen_end(gen_end),
    .gen_start(a_gen_start), .reset_player(a_reset_player), .time_left(a_time_left),
    .lives(a_lives), .mazes_complete(a_mazes),
`ifdef MAZE_SESSION_HIGH_SCORE_EN
    .high_score(a_high_score),
`endif
    .playing(a_playing), .game_over(a_game_over), .session_state(a_state)
  );

  maze_session_controller #(.COUNT_WIDTH(2), .TIME_LIMIT(2)) dut_small (
    .clock(clock), .reset(reset), .start(start), .tick(tick),
    .player_at_end(player_at_end), .gen_end(gen_end),
    .gen_start(b_gen_start), .reset_player(b_reset_player), .time_left(b_time_left),
    .lives(b_lives), .mazes_complete(b_mazes),
`ifdef MAZE_SESSION_HIGH_SCORE_EN
    .high_score(b_high_score),
`endif
    .playing(b_playing), .game_over(b_game_over), .session_state(b_state)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic reset_all();
    reset = 1'b0; start = 1'b0; tick = 1'b0; player_at_end = 1'b0; gen_end = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic begin_session();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic regen();
    gen_end = 1'b0;
    cyc(3);
    gen_end = 1'b1;
    cyc(1);
  endtask

  task automatic complete_and_regen();
    player_at_end = 1'b1;
    cyc(1);
    player_at_end = 1'b0;
    cyc(1);
    regen();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cyc(2);
    compared++; if (a_state !== S_IDLE) begin mismatched++; $display("FAIL reset_state: got %0d want %0d", a_state, S_IDLE); end
    compared++; if (a_gen_start !== 1'b0) begin mismatched++; $display("FAIL reset_gen_start: got %b want 0", a_gen_start); end
    compared++; if (a_reset_player !== 1'b1) begin mismatched++; $display("FAIL reset_reset_player: got %b want 1", a_reset_player); end
    compared++; if (a_time_left !== 8'd0) begin mismatched++; $display("FAIL reset_time_left: got %0d want 0", a_time_left); end
    compared++; if (a_lives !== 4'd0) begin mismatched++; $display("FAIL reset_lives: got %0d want 0", a_lives); end
    compared++; if (a_mazes !== 8'd0) begin mismatched++; $display("FAIL reset_mazes: got %0d want 0", a_mazes); end
    compared++; if ({a_playing, a_game_over} !== 2'b00) begin mismatched++; $display("FAIL reset_flags: got %b want 00", {a_playing, a_game_over}); end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_start();
    int p0;
    reset_all();
    p0 = a_pulses;
    begin_session();
    compared++; if (a_gen_start !== 1'b1) begin mismatched++; $display("FAIL start_gen_start_high: got %b want 1", a_gen_start); end
    cyc(1);
    compared++; if (a_gen_start !== 1'b0) begin mismatched++; $display("FAIL start_gen_start_one_cycle: got %b want 0", a_gen_start); end
    cyc(3);
    compared++; if (a_playing !== 1'b0) begin mismatched++; $display("FAIL stale_gen_end: playing got %b want 0", a_playing); end
    gen_end = 1'b0;
    cyc(5);
    gen_end = 1'b1;
    cyc(1);
    compared++; if (a_playing !== 1'b1) begin mismatched++; $display("FAIL start_playing: got %b want 1", a_playing); end
    compared++; if (a_reset_player !== 1'b0) begin mismatched++; $display("FAIL start_reset_player: got %b want 0", a_reset_player); end
    compared++; if (a_time_left !== 8'd60) begin mismatched++; $display("FAIL start_time_left: got %0d want 60", a_time_left); end
    compared++; if (a_lives !== 4'd3) begin mismatched++; $display("FAIL start_lives: got %0d want 3", a_lives); end
    compared++; if (a_pulses - p0 !== 1) begin mismatched++; $display("FAIL start_pulses: got %0d want 1", a_pulses - p0); end
  endtask

  task automatic test_completions();
    int p0;
    p0 = a_pulses;
    for (int i = 1; i <= 3; i++) begin
      player_at_end = 1'b1;
      cyc(1);
      compared++; if (a_mazes !== 8'(i)) begin mismatched++; $display("FAIL completion_count_%0d: got %0d want %0d", i, a_mazes, i); end
      if (i < 3) player_at_end = 1'b0;
      cyc(1);
      compared++; if (a_gen_start !== 1'b1) begin mismatched++; $display("FAIL completion_regen_%0d: gen_start got %b want 1", i, a_gen_start); end
      regen();
    end
    cyc(2);
    compared++; if (a_mazes !== 8'd3) begin mismatched++; $display("FAIL held_exit_no_count: got %0d want 3", a_mazes); end
    compared++; if (a_playing !== 1'b1) begin mismatched++; $display("FAIL held_exit_playing: got %b want 1", a_playing); end
    player_at_end = 1'b0;
    compared++; if (a_pulses - p0 !== 3) begin mismatched++; $display("FAIL completion_pulses: got %0d want 3", a_pulses - p0); end
  endtask

  task automatic test_same_cycle();
    tick = 1'b1;
    cyc(59);
    tick = 1'b0;
    compared++; if (a_time_left !== 8'd1) begin mismatched++; $display("FAIL countdown_to_one: got %0d want 1", a_time_left); end
    tick = 1'b1;
    player_at_end = 1'b1;
    cyc(1);
    tick = 1'b0;
    player_at_end = 1'b0;
    compared++; if (a_mazes !== 8'd4) begin mismatched++; $display("FAIL same_cycle_count: got %0d want 4", a_mazes); end
    compared++; if (a_lives !== 4'd3) begin mismatched++; $display("FAIL same_cycle_lives: got %0d want 3", a_lives); end
    compared++; if (a_state !== S_LEVEL_DONE) begin mismatched++; $display("FAIL same_cycle_state: got %0d want %0d", a_state, S_LEVEL_DONE); end
    compared++; if (a_time_left !== 8'd1) begin mismatched++; $display("FAIL same_cycle_time_left: got %0d want 1", a_time_left); end
  endtask

  task automatic test_timeout();
    reset_all();
    begin_session();
    regen();
    compared++; if (b_time_left !== 8'd2) begin mismatched++; $display("FAIL timeout_load: got %0d want 2", b_time_left); end
    for (int k = 1; k <= 3; k++) begin
      tick = 1'b1;
      cyc(2);
      tick = 1'b0;
      compared++; if (b_lives !== 4'(3 - k)) begin mismatched++; $display("FAIL timeout_lives_%0d: got %0d want %0d", k, b_lives, 3 - k); end
      if (k < 3) begin
        compared++; if (b_gen_start !== 1'b1) begin mismatched++; $display("FAIL timeout_regen_%0d: gen_start got %b want 1", k, b_gen_start); end
        regen();
      end
    end
    compared++; if (b_game_over !== 1'b1) begin mismatched++; $display("FAIL timeout_game_over: got %b want 1", b_game_over); end
    compared++; if (b_reset_player !== 1'b1) begin mismatched++; $display("FAIL timeout_reset_player: got %b want 1", b_reset_player); end
    compared++; if (b_playing !== 1'b0) begin mismatched++; $display("FAIL timeout_playing: got %b want 0", b_playing); end
    compared++; if (b_time_left !== 8'd0) begin mismatched++; $display("FAIL timeout_time_left: got %0d want 0", b_time_left); end
  endtask

  task automatic test_saturation();
    logic [1:0] want;
    reset_all();
    begin_session();
    regen();
    for (int i = 1; i <= 5; i++) begin
      want = (i > 3) ? 2'd3 : 2'(i);
      player_at_end = 1'b1;
      cyc(1);
      player_at_end = 1'b0;
      compared++; if (b_mazes !== want) begin mismatched++; $display("FAIL saturation_%0d: got %0d want %0d", i, b_mazes, want); end
      cyc(1);
      regen();
    end
  endtask

`ifdef MAZE_SESSION_HIGH_SCORE_EN
  task automatic test_high_score();
    reset_all();
    begin_session();
    regen();
    repeat (4) complete_and_regen();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc(60);
      tick = 1'b0;
      if (k < 2) regen();
    end
    compared++; if (a_game_over !== 1'b1) begin mismatched++; $display("FAIL hs_game_over_1: got %b want 1", a_game_over); end
    compared++; if (a_high_score !== 8'd4) begin mismatched++; $display("FAIL hs_session1: got %0d want 4", a_high_score); end
    begin_session();
    compared++; if (a_high_score !== 8'd4) begin mismatched++; $display("FAIL hs_survives_start: got %0d want 4", a_high_score); end
    compared++; if (a_mazes !== 8'd0) begin mismatched++; $display("FAIL hs_start_clears_mazes: got %0d want 0", a_mazes); end
    regen();
    repeat (2) complete_and_regen();
    for (int k = 0; k < 3; k++) begin
      tick = 1'b1;
      cyc(60);
      tick = 1'b0;
      if (k < 2) regen();
    end
    compared++; if (a_mazes !== 8'd2) begin mismatched++; $display("FAIL hs_session2_mazes: got %0d want 2", a_mazes); end
    compared++; if (a_high_score !== 8'd4) begin mismatched++; $display("FAIL hs_session2: got %0d want 4", a_high_score); end
  endtask
`endif

  task automatic test_reset_mid_play();
`ifndef MAZE_SESSION_HIGH_SCORE_EN
    reset_all();
`endif
    begin_session();
    regen();
    tick = 1'b1;
    cyc(3);
    tick = 1'b0;
    compared++; if (a_time_left !== 8'd57) begin mismatched++; $display("FAIL mid_play_time_left: got %0d want 57", a_time_left); end
    reset = 1'b0;
    cyc(1);
    compared++; if (a_state !== S_IDLE) begin mismatched++; $display("FAIL mid_reset_state: got %0d want %0d", a_state, S_IDLE); end
    compared++; if ({a_gen_start, a_reset_player, a_playing, a_game_over} !== 4'b0100) begin
      mismatched++; $display("FAIL mid_reset_flags: got %b want 0100", {a_gen_start, a_reset_player, a_playing, a_game_over});
    end
    compared++; if ({a_time_left, a_lives, a_mazes} !== 20'd0) begin
      mismatched++; $display("FAIL mid_reset_values: time %0d lives %0d mazes %0d want all 0", a_time_left, a_lives, a_mazes);
    end
`ifdef MAZE_SESSION_HIGH_SCORE_EN
    compared++; if (a_high_score !== 8'd0) begin mismatched++; $display("FAIL mid_reset_high_score: got %0d want 0", a_high_score); end
`endif
    reset = 1'b1;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(1);
    test_reset();
    test_start();
    test_completions();
    test_same_cycle();
    test_timeout();
    test_saturation();
`ifdef MAZE_SESSION_HIGH_SCORE_EN
    test_high_score();
`endif
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
